// File: rtl/ldlt_solve.sv
// Solves A x = b from packed LDL^T factors: forward substitution, diagonal scaling, back substitution.
// Define LDLT_SOLVE_SAT_EN to saturate every write-back; otherwise write-backs wrap to WORD_LEN bits.
module ldlt_solve #(
  parameter int WORD_LEN = 14,
  parameter int FRACTION = 7,
  parameter int NODE_NUM = 1,
  localparam int DIM = 6 * NODE_NUM,
  localparam int L_SIZE = (DIM * DIM + DIM) / 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [L_SIZE*WORD_LEN-1:0]   i_L,
  input  logic [DIM*WORD_LEN-1:0]      i_b,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic                         o_err,
  output logic [DIM*WORD_LEN-1:0]      o_x
);

  localparam int ACC_W = 2 * WORD_LEN + 4;
  localparam int QW    = WORD_LEN + FRACTION + 1;
  localparam int L_IW  = $clog2(L_SIZE);
  localparam int D_IW  = $clog2(DIM);
  localparam logic [WORD_LEN-1:0] MAX_W = {1'b0, {(WORD_LEN-1){1'b1}}};
  localparam logic [WORD_LEN-1:0] NEG_MAX_W = {1'b1, {(WORD_LEN-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_DIAG, S_BWD, S_DONE} state_e;

  state_e                              state_q, state_d;
  logic [9:0]                          cnt_i_q, cnt_i_d, cnt_k_q, cnt_k_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [L_SIZE-1:0][WORD_LEN-1:0]     l_q, l_d;
  logic [DIM-1:0][WORD_LEN-1:0]        b_q, b_d, x_q, x_d;
  logic                                err_q, err_d, valid_q, valid_d;

  logic [9:0]                          mac_row, mac_col;
  logic [20:0]                         r21, lidx_full, i21, didx_full;
  logic                                mac_en;
  logic [WORD_LEN-1:0]                 l_word, x_k, x_i, b_i, d_i, sub_src;
  logic signed [2*WORD_LEN-1:0]        prod, prod_sh;
  logic signed [ACC_W-1:0]             prod_ext;
  logic signed [ACC_W:0]               diff;
  logic signed [QW-1:0]                num, den, quot;

  // Narrow a wide signed value to one buffer word (saturating or wrapping).
  function automatic logic [WORD_LEN-1:0] narrow(input logic signed [ACC_W:0] v);
`ifdef LDLT_SOLVE_SAT_EN
    logic signed [ACC_W:0] hi, lo;
    hi = {{(ACC_W-WORD_LEN+2){1'b0}}, {(WORD_LEN-1){1'b1}}};
    lo = {{(ACC_W-WORD_LEN+2){1'b1}}, {(WORD_LEN-1){1'b0}}};
    if (v > hi)      return MAX_W;
    else if (v < lo) return {1'b1, {(WORD_LEN-1){1'b0}}};
    else             return WORD_LEN'(v);
`else
    return WORD_LEN'(v);
`endif
  endfunction

  always_comb begin
    // MAC operand fetch: L[i][k]*y[k] going forward, L[k][i]*x[k] going backward
    mac_row   = (state_q == S_BWD) ? cnt_k_q : cnt_i_q;
    mac_col   = (state_q == S_BWD) ? cnt_i_q : cnt_k_q;
    r21       = {11'd0, mac_row};
    lidx_full = ((r21 * (r21 + 21'd1)) >> 1) + {11'd0, mac_col};
    i21       = {11'd0, cnt_i_q};
    didx_full = ((i21 * (i21 + 21'd1)) >> 1) + i21;
    mac_en    = ((state_q == S_FWD) && (cnt_k_q < cnt_i_q)) ||
                ((state_q == S_BWD) && (cnt_k_q < 10'(DIM)));
    l_word    = (lidx_full < 21'(L_SIZE)) ? l_q[lidx_full[L_IW-1:0]] : '0;
    d_i       = (didx_full < 21'(L_SIZE)) ? l_q[didx_full[L_IW-1:0]] : '0;
    x_k       = (cnt_k_q < 10'(DIM)) ? x_q[cnt_k_q[D_IW-1:0]] : '0;
    x_i       = (cnt_i_q < 10'(DIM)) ? x_q[cnt_i_q[D_IW-1:0]] : '0;
    b_i       = (cnt_i_q < 10'(DIM)) ? b_q[cnt_i_q[D_IW-1:0]] : '0;
    prod      = $signed(l_word) * $signed(x_k);
    prod_sh   = prod >>> FRACTION;
    prod_ext  = {{4{prod_sh[2*WORD_LEN-1]}}, prod_sh};
    sub_src   = (state_q == S_FWD) ? b_i : x_i;
    diff      = $signed({{(ACC_W-WORD_LEN+1){sub_src[WORD_LEN-1]}}, sub_src}) -
                $signed({acc_q[ACC_W-1], acc_q});
    // Numerator carries one guard bit so that -MIN / -1 cannot wrap before narrowing
    num       = $signed({x_i[WORD_LEN-1], x_i, {FRACTION{1'b0}}});
    den       = (d_i == '0) ? QW'(1) : $signed({{(QW-WORD_LEN){d_i[WORD_LEN-1]}}, d_i});
    quot      = num / den;
  end

  always_comb begin
    state_d = state_q;
    cnt_i_d = cnt_i_q;
    cnt_k_d = cnt_k_q;
    acc_d   = acc_q;
    l_d     = l_q;
    b_d     = b_q;
    x_d     = x_q;
    err_d   = err_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        l_d     = i_L;
        b_d     = i_b;
        err_d   = 1'b0;
        cnt_i_d = '0;
        cnt_k_d = '0;
        acc_d   = '0;
        state_d = S_FWD;
      end
      S_FWD: if (mac_en) begin
        acc_d   = acc_q + prod_ext;
        cnt_k_d = cnt_k_q + 10'd1;
      end else begin
        x_d[cnt_i_q[D_IW-1:0]] = narrow(diff);
        acc_d   = '0;
        cnt_k_d = '0;
        if (cnt_i_q == 10'(DIM - 1)) begin
          cnt_i_d = '0;
          state_d = S_DIAG;
        end else begin
          cnt_i_d = cnt_i_q + 10'd1;
        end
      end
      S_DIAG: begin
        if (d_i == '0) begin
          x_d[cnt_i_q[D_IW-1:0]] = x_i[WORD_LEN-1] ? NEG_MAX_W : MAX_W;
          err_d = 1'b1;
        end else begin
          x_d[cnt_i_q[D_IW-1:0]] = narrow({{(ACC_W+1-QW){quot[QW-1]}}, quot});
        end
        if (cnt_i_q == 10'(DIM - 1)) begin
          cnt_k_d = 10'(DIM);
          state_d = S_BWD;
        end else begin
          cnt_i_d = cnt_i_q + 10'd1;
        end
      end
      S_BWD: if (mac_en) begin
        acc_d   = acc_q + prod_ext;
        cnt_k_d = cnt_k_q + 10'd1;
      end else begin
        x_d[cnt_i_q[D_IW-1:0]] = narrow(diff);
        acc_d = '0;
        if (cnt_i_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_i_d = cnt_i_q - 10'd1;
          cnt_k_d = cnt_i_q;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_i_q <= '0;
      cnt_k_q <= '0;
      acc_q   <= '0;
      l_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_i_q <= cnt_i_d;
      cnt_k_q <= cnt_k_d;
      acc_q   <= acc_d;
      l_q     <= l_d;
      b_q     <= b_d;
      x_q     <= x_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_x     = x_q;

endmodule

// File: tb/tb_ldlt_solve.sv
// Self-checking bench for ldlt_solve: directed cases plus randomized solves against a plain-arithmetic model.
module tb_ldlt_solve;
  localparam int W = 14, F = 7, DIM = 6, LS = 21;

  logic              clk = 1'b0;
  logic              rst_n, i_start;
  logic [LS*W-1:0]   i_L;
  logic [DIM*W-1:0]  i_b;
  logic              o_busy, o_valid, o_err;
  logic [DIM*W-1:0]  o_x;

  ldlt_solve dut (.clk(clk), .rst_n(rst_n), .i_start(i_start), .i_L(i_L), .i_b(i_b),
                  .o_busy(o_busy), .o_valid(o_valid), .o_err(o_err), .o_x(o_x));

  always #5 clk = ~clk;

  int     n_checks = 0, n_errors = 0;
  longint lm[DIM][DIM];
  longint bv[DIM];
  longint xe[DIM];
  longint err_e;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v);
    longint r;
    r = v & 64'h3FFF;
    if (r >= 8192) r = r - 16384;
    return r;
  endfunction

  function automatic longint nar(input longint v);
`ifdef LDLT_SOLVE_SAT_EN
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
`else
    return sx(v);
`endif
  endfunction

  function automatic longint xo(input int i);
    logic [W-1:0] w;
    w = o_x[i*W +: W];
    return sx(longint'(w));
  endfunction

  // Reference: L y = b, z = y / D, L^T x = z, each result narrowed to one word
  task automatic model();
    longint y[DIM], z[DIM], s;
    err_e = 0;
    for (int i = 0; i < DIM; i++) begin
      s = 0;
      for (int k = 0; k < i; k++) s += (lm[i][k] * y[k]) >>> F;
      y[i] = nar(bv[i] - s);
    end
    for (int i = 0; i < DIM; i++) begin
      if (lm[i][i] == 0) begin
        z[i] = (y[i] >= 0) ? 8191 : -8191;
        err_e = 1;
      end else begin
        z[i] = nar((y[i] * 128) / lm[i][i]);
      end
    end
    for (int i = DIM - 1; i >= 0; i--) begin
      s = 0;
      for (int k = i + 1; k < DIM; k++) s += (lm[k][i] * xe[k]) >>> F;
      xe[i] = nar(z[i] - s);
    end
  endtask

  task automatic load();
    for (int i = 0; i < DIM; i++) begin
      i_b[i*W +: W] = bv[i][W-1:0];
      for (int j = 0; j <= i; j++) i_L[(i*(i+1)/2 + j)*W +: W] = lm[i][j][W-1:0];
    end
  endtask

  task automatic diag_only(input longint d);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) lm[i][j] = (i == j) ? d : 0;
  endtask

  task automatic run_solve(input string tag, input int extra_start);
    int lat;
    model();
    load();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); i_start = 1'b0;
    chk($sformatf("%s_busy", tag), o_busy, 1);
    lat = 0;
    for (int n = 1; n <= 120 && lat == 0; n++) begin
      if (n == extra_start) i_start = 1'b1;
      @(posedge clk);
      @(negedge clk); i_start = 1'b0;
      if (o_valid) lat = n;
    end
    chk($sformatf("%s_lat", tag), lat, 49);
    for (int i = 0; i < DIM; i++) chk($sformatf("%s_x%0d", tag, i), xo(i), xe[i]);
    chk($sformatf("%s_err", tag), o_err, err_e);
    @(posedge clk); @(negedge clk);
    chk($sformatf("%s_pulse", tag), o_valid, 0);
    chk($sformatf("%s_idle", tag), o_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_L = '0; i_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_x", (o_x == '0), 1);
    rst_n = 1'b1;

    // 1 identity
    diag_only(128);
    bv = '{128, 256, -128, 0, 64, -64};
    run_solve("ident", 0);
    for (int i = 0; i < DIM; i++) chk($sformatf("ident_const%0d", i), xo(i), bv[i]);

    // 2 scaling
    diag_only(256);
    bv = '{128, 128, 128, 128, 128, 128};
    run_solve("scale", 0);
    chk("scale_const", xo(3), 64);

    // 3 coupling
    diag_only(128);
    lm[1][0] = 64;
    bv = '{128, 128, 0, 0, 0, 0};
    run_solve("couple", 0);
    chk("couple_c0", xo(0), 96);
    chk("couple_c1", xo(1), 64);

    // 4 zero pivot, error held while idle
    diag_only(128);
    lm[2][2] = 0;
    bv = '{0, 0, 128, 0, 0, 0};
    run_solve("zpiv", 0);
    chk("zpiv_c2", xo(2), 8191);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("zpiv_hold_err", o_err, 1);
    chk("zpiv_hold_x", xo(2), 8191);

    // 5 overflow (also clears the sticky error)
    diag_only(1);
    bv = '{128, 128, 128, 128, 128, 128};
    run_solve("ovf", 0);
`ifdef LDLT_SOLVE_SAT_EN
    chk("ovf_const", xo(0), 8191);
`else
    chk("ovf_const", xo(0), 0);
`endif

    // 6a start ignored mid-solve
    diag_only(128);
    lm[3][1] = -40; lm[5][2] = 100;
    bv = '{300, -200, 50, 1000, -7, 77};
    run_solve("ctl_start", 10);

    // 6b reset mid-solve, then a fresh solve
    load();
    @(negedge clk); i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); i_start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ctl_rst_busy", o_busy, 0);
    chk("ctl_rst_valid", o_valid, 0);
    chk("ctl_rst_x", (o_x == '0), 1);
    @(negedge clk); rst_n = 1'b1;
    run_solve("ctl_fresh", 0);

    // randomized solves
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DIM; i++) begin
        bv[i] = sx(longint'($urandom));
        for (int j = 0; j < DIM; j++) lm[i][j] = 0;
        for (int j = 0; j < i; j++)
          lm[i][j] = (t < 10) ? sx(longint'($urandom_range(0, 511))) - 256 : sx(longint'($urandom));
        lm[i][i] = ($urandom_range(0, 7) == 0) ? 0 : sx(longint'($urandom));
      end
      run_solve($sformatf("rnd%0d", t), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
